// File: rtl/seq_gen.sv
// seq_gen -- serial frame generator.
// Emits a latched DATA_W-bit pattern MSB first on `out`, repeated `rep` times
// back to back (rep=0 counts as one frame). A one-cycle `done` pulse follows
// the last bit. Every output is registered.
//
// Optional feature: define SEQ_GEN_PARITY_EN to append one even-parity bit
// (XOR of the pattern) to every frame, making each frame DATA_W+1 bits long.
module seq_gen #(
    parameter int DATA_W = 8,
    parameter int REP_W  = 4
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] data_in,
    input  logic [REP_W-1:0]  rep,
    output logic              out,
    output logic              out_vld,
    output logic              busy,
    output logic              done
);

`ifdef SEQ_GEN_PARITY_EN
    localparam int FRAME_LEN = DATA_W + 1;
`else
    localparam int FRAME_LEN = DATA_W;
`endif

    // The bit counter also holds FRAME_LEN, a marker meaning "last frame is
    // fully sent", so SHIFT spends one more edge before moving to FIN.
    localparam int CNT_W = $clog2(FRAME_LEN + 1);

    localparam logic [CNT_W-1:0] LAST_BIT   = CNT_W'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0] FRAME_DONE = CNT_W'(FRAME_LEN);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [REP_W-1:0] REP_ONE    = REP_W'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        FIN   = 2'd2
    } state_t;

    state_t            state,     state_nxt;
    logic [DATA_W-1:0] shift_reg, shift_nxt;
    logic [DATA_W-1:0] pat_reg,   pat_nxt;
    logic [REP_W-1:0]  rep_cnt,   rep_nxt;
    logic [CNT_W-1:0]  bit_cnt,   cnt_nxt;
    logic              out_nxt, vld_nxt, busy_nxt, done_nxt;
    logic              frame_bit;

    // Select the bit to send this cycle: data MSB, or the trailing parity bit.
`ifdef SEQ_GEN_PARITY_EN
    assign frame_bit = (bit_cnt == CNT_W'(DATA_W)) ? ^pat_reg : shift_reg[DATA_W-1];
`else
    assign frame_bit = shift_reg[DATA_W-1];
`endif

    // Next-state and next-output logic for the IDLE/SHIFT/FIN controller.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // one unassigned, which would otherwise infer a latch.
        state_nxt = state;
        shift_nxt = shift_reg;
        pat_nxt   = pat_reg;
        rep_nxt   = rep_cnt;
        cnt_nxt   = bit_cnt;
        out_nxt   = 1'b0;
        vld_nxt   = 1'b0;
        busy_nxt  = 1'b0;
        done_nxt  = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = SHIFT;
                    shift_nxt = data_in;
                    pat_nxt   = data_in;
                    rep_nxt   = (rep == '0) ? REP_ONE : rep;
                    cnt_nxt   = '0;
                    busy_nxt  = 1'b1;
                end
            end

            SHIFT: begin
                busy_nxt = 1'b1;
                if (bit_cnt == FRAME_DONE) begin
                    state_nxt = FIN;
                    done_nxt  = 1'b1;
                end else begin
                    out_nxt   = frame_bit;
                    vld_nxt   = 1'b1;
                    shift_nxt = shift_reg << 1;
                    if (bit_cnt == LAST_BIT) begin
                        if (rep_cnt > REP_ONE) begin
                            // Reload here so the next frame follows with no gap.
                            shift_nxt = pat_reg;
                            rep_nxt   = rep_cnt - REP_ONE;
                            cnt_nxt   = '0;
                        end else begin
                            cnt_nxt = FRAME_DONE;
                        end
                    end else begin
                        cnt_nxt = bit_cnt + CNT_ONE;
                    end
                end
            end

            FIN: begin
                state_nxt = IDLE;
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State, datapath and registered outputs; async reset aborts any transfer.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            // NOTE: the pattern and shift registers are reset along with the
            // control state so nothing from an aborted frame survives reset.
            state     <= IDLE;
            shift_reg <= '0;
            pat_reg   <= '0;
            rep_cnt   <= '0;
            bit_cnt   <= '0;
            out       <= 1'b0;
            out_vld   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // values computed before this edge, independent of statement order.
            state     <= state_nxt;
            shift_reg <= shift_nxt;
            pat_reg   <= pat_nxt;
            rep_cnt   <= rep_nxt;
            bit_cnt   <= cnt_nxt;
            out       <= out_nxt;
            out_vld   <= vld_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
        end
    end

endmodule

// File: doc/seq_gen.md
SEQ_GEN -- requirements
Module: seq_gen

Interface
REQ-001 Parameter DATA_W, default 8, SHALL set the frame width in bits.
REQ-002 Parameter REP_W, default 4, SHALL set the repeat-count field width.
REQ-003 sys_clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 sys_rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 start  input  1  SHALL request a transmission; sampled only while idle.
REQ-006 data_in  input  DATA_W  SHALL be the frame pattern; latched on an accepted start.
REQ-007 rep  input  REP_W  SHALL be the frame repeat count; latched on an accepted start.
REQ-008 out  output  1  SHALL be the serial bit stream, MSB first, for the downstream sequence detector's in port.
REQ-009 out_vld  output  1  SHALL be high in every cycle in which out carries a frame bit.
REQ-010 busy  output  1  SHALL be high from the cycle after an accepted start until done is asserted.
REQ-011 done  output  1  SHALL pulse high for exactly one cycle after the last bit of the last frame.

Function
REQ-012 States SHALL be IDLE, SHIFT and FIN; all outputs SHALL be registered.
REQ-013 In IDLE, start=1 SHALL be accepted: latch data_in into the pattern register and the shift register, load the repeat counter, clear the bit counter, and go to SHIFT.
REQ-014 rep=0 SHALL be treated as rep=1; rep=k SHALL emit k back-to-back frames with no gap cycles.
REQ-015 Latency: start accepted at edge N SHALL present the first bit (data_in[DATA_W-1]) on out with out_vld=1 from edge N+1.
REQ-016 In SHIFT, each edge SHALL advance one bit (left shift, MSB to out), and the bit counter SHALL increment from 0 to DATA_W-1.
REQ-017 At the last bit of a frame with frames remaining, the next edge SHALL reload the shift register from the pattern register, decrement the repeat counter, and remain in SHIFT.
REQ-018 At the last bit of the last frame, the next edge SHALL go to FIN with out=0, out_vld=0 and done=1; the following edge SHALL go to IDLE with done=0 and busy=0.
REQ-019 start SHALL be ignored in SHIFT and FIN; data_in and rep changes after acceptance SHALL NOT affect the transmission in progress.
REQ-020 start held high SHALL be re-accepted only in IDLE, giving a minimum one-cycle idle gap between transmissions.
REQ-021 Outside SHIFT, out and out_vld SHALL be 0.

Reset
REQ-022 While sys_rst_n=0, the state SHALL be IDLE, and out, out_vld, busy, done, the counters and the shift/pattern registers SHALL be 0, independent of sys_clk.
REQ-023 Reset asserted mid-transmission SHALL abort it immediately; no done pulse SHALL follow.
REQ-024 After deassertion, the first edge SHALL sample start normally.

Configuration
REQ-025 With macro SEQ_GEN_PARITY_EN defined, each frame SHALL carry one extra trailing even-parity bit (XOR of the DATA_W pattern bits) with out_vld=1, making the frame DATA_W+1 cycles long.
REQ-026 Without SEQ_GEN_PARITY_EN, frames SHALL be exactly DATA_W bits and no parity logic SHALL be present.

Verification
REQ-027 data_in=8'b11011010, rep=1, start at edge N -> out=1,1,0,1,1,0,1,0 on edges N+1..N+8 with out_vld=1; done=1 at N+9; busy=0 at N+10.
REQ-028 Same data, rep=2 -> 16 contiguous valid bits (pattern twice, no gap); single done pulse at N+17.
REQ-029 rep=0 -> output identical to the rep=1 case.
REQ-030 start pulsed at N+3 with data_in=8'hFF during the transmission -> ignored; stream unchanged.
REQ-031 sys_rst_n=0 asynchronously at mid-frame bit 4 -> out, out_vld and busy go to 0 before the next edge; no done pulse follows; a new start after release transmits normally.
REQ-032 SEQ_GEN_PARITY_EN defined, data 8'b11011010, rep=1 -> 8 data bits, then parity bit 1 at N+9; done at N+10.
